// File: rtl/div_round_stage.sv
// Divider post-stage: round quotient mantissa and saturate exponent (rounding mode: DIV_ROUND_RNE_EN = RNE, else truncate).
// Latency 2 cycles; two-stage valid/ready pipe, full throughput, outputs hold while out_ready is low.
module div_round_stage #(
  parameter int MANT_SIZE = 14,
  parameter int TE_SIZE   = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3*MANT_SIZE-1:0]   mant_in,
  input  logic [TE_SIZE-1:0]       te_in,
  input  logic                     sign_in,
  input  logic [1:0]               special_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MANT_SIZE-1:0]     mant_out,
  output logic [TE_SIZE-1:0]       te_out,
  output logic                     sign_out,
  output logic [1:0]               special_out,
  output logic                     ovf
);

  localparam int M = MANT_SIZE;
  localparam logic [TE_SIZE:0] TE_MAX = {2'b00, {(TE_SIZE-1){1'b1}}};

  typedef struct packed {
    logic [M-1:0]       keep;
    logic               guard;
    logic               sticky;
    logic [TE_SIZE-1:0] te;
    logic               sign;
    logic [1:0]         special;
  } s1_t;

  s1_t                s1_q;
  logic               s1_valid;
  logic               s2_valid;
  logic               s1_adv;
  logic               s2_adv;
  logic               round_up;
  logic [M:0]         sum;
  logic [TE_SIZE:0]   te_sum;
  logic [M-1:0]       mant_nx;
  logic [TE_SIZE-1:0] te_nx;
  logic               ovf_nx;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s2_adv || !s1_valid;
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign out_valid = s2_valid;

`ifdef DIV_ROUND_RNE_EN
  assign round_up = s1_q.guard && (s1_q.sticky || s1_q.keep[0]);
`else
  // Truncation: guard/sticky are still captured so both builds share one S1 layout.
  logic unused_round_bits;
  assign unused_round_bits = s1_q.guard | s1_q.sticky;
  assign round_up = 1'b0;
`endif

  // Bit above the leading-one position is always zero from the divider.
  logic unused_mant_msb;
  assign unused_mant_msb = mant_in[3*M-1];

  always_comb begin
    sum     = {1'b0, s1_q.keep} + {{M{1'b0}}, round_up};
    te_sum  = {s1_q.te[TE_SIZE-1], s1_q.te} + {{TE_SIZE{1'b0}}, sum[M]};
    mant_nx = sum[M] ? {1'b1, {(M-1){1'b0}}} : sum[M-1:0];
    te_nx   = te_sum[TE_SIZE-1:0];
    ovf_nx  = 1'b0;
    if ($signed(te_sum) > $signed(TE_MAX)) begin
      mant_nx = '1;
      te_nx   = TE_MAX[TE_SIZE-1:0];
      ovf_nx  = 1'b1;
    end
    // Zero and NaR bypass rounding entirely.
    if (s1_q.special != 2'b00) begin
      mant_nx = '0;
      te_nx   = '0;
      ovf_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s1_q        <= '0;
      mant_out    <= '0;
      te_out      <= '0;
      sign_out    <= 1'b0;
      special_out <= 2'b00;
      ovf         <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_q.keep    <= mant_in[3*M-2:2*M-1];
          s1_q.guard   <= mant_in[2*M-2];
          s1_q.sticky  <= |mant_in[2*M-3:0];
          s1_q.te      <= te_in;
          s1_q.sign    <= sign_in;
          s1_q.special <= special_in;
        end
      end
      // Payload only reloads with real data so idle outputs keep their last value.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          mant_out    <= mant_nx;
          te_out      <= te_nx;
          sign_out    <= s1_q.sign;
          special_out <= s1_q.special;
          ovf         <= ovf_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_round_stage.sv
// Randomized + directed bench for div_round_stage against an arithmetic rounding model.
module tb_div_round_stage;
  localparam int M  = 14;
  localparam int TE = 7;
`ifdef DIV_ROUND_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3*M-1:0]  mant_in;
  logic [TE-1:0]   te_in;
  logic            sign_in;
  logic [1:0]      special_in;
  logic            out_valid;
  logic            out_ready;
  logic [M-1:0]    mant_out;
  logic [TE-1:0]   te_out;
  logic            sign_out;
  logic [1:0]      special_out;
  logic            ovf;

  div_round_stage #(.MANT_SIZE(M), .TE_SIZE(TE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mant_in(mant_in), .te_in(te_in), .sign_in(sign_in), .special_in(special_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .te_out(te_out), .sign_out(sign_out),
    .special_out(special_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [M-1:0]  mant;
    logic [TE-1:0] te;
    logic          sign;
    logic [1:0]    special;
    logic          ovf;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  bit   stalled = 1'b0;
  res_t prev_cur = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Rounding from the numeric value: remainder compared against half an ulp.
  function automatic res_t ref_model(input logic [3*M-1:0] m, input int te,
                                     input logic s, input logic [1:0] sp);
    res_t r;
    longint unsigned mv, keep, rem, half;
    int t;
    bit up;
    r.sign = s;
    r.special = sp;
    r.ovf = 1'b0;
    if (sp != 2'b00) begin
      r.mant = '0;
      r.te = '0;
      return r;
    end
    mv   = 64'(m);
    keep = (mv >> (2*M-1)) % (64'd1 << M);
    rem  = mv % (64'd1 << (2*M-1));
    half = 64'd1 << (2*M-2);
    up   = RNE && ((rem > half) || (rem == half && (keep % 2) == 1));
    keep = keep + 64'(up);
    t    = te;
    if (keep == (64'd1 << M)) begin
      keep = 64'd1 << (M-1);
      t = t + 1;
    end
    if (t > (2**(TE-1) - 1)) begin
      t = 2**(TE-1) - 1;
      keep = (64'd1 << M) - 1;
      r.ovf = 1'b1;
    end
    r.mant = keep[M-1:0];
    r.te = t[TE-1:0];
    return r;
  endfunction

  function automatic logic [3*M-1:0] rnd_mant();
    logic [3*M-1:0] r;
    r = (3*M)'({$urandom(), $urandom()});
    r[3*M-1] = 1'b0;
    r[3*M-2] = 1'b1;
    return r;
  endfunction

  task automatic step(input logic v, input logic [3*M-1:0] m, input logic [TE-1:0] te,
                      input logic s, input logic [1:0] sp, input logic ordy, output bit acc);
    bit   vis, pop, exp_rdy;
    res_t cur;
    ent_t e;
    @(negedge clk);
    vis = (q.size() > 0) && (edge_cnt >= q[0].acc + 1);
    cur = {mant_out, te_out, sign_out, special_out, ovf};
    chk("out_valid", out_valid, vis);
    if (vis) chk("payload", cur, q[0].r);
    else chk("idle_hold", cur, prev_cur);
    if (stalled) chk("stall_hold", cur, prev_cur);
    in_valid = v; mant_in = m; te_in = te; sign_in = s; special_in = sp; out_ready = ordy;
    #1;
    exp_rdy = !(q.size() == 2 && !ordy);
    chk("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    pop = vis && ordy;
    stalled = vis && !ordy;
    prev_cur = cur;
    @(posedge clk);
    edge_cnt++;
    if (pop) e = q.pop_front();
    if (acc) q.push_back('{ref_model(m, int'($signed(te)), s, sp), edge_cnt});
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 2'b00, 1'b1, a);
    step(1'b0, '0, '0, 1'b0, 2'b00, 1'b1, a);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    res_t cur;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    stalled = 1'b0;
    prev_cur = '0;
    #1;
    cur = {mant_out, te_out, sign_out, special_out, ovf};
    chk("rst_out_valid", out_valid, 0);
    chk("rst_payload", cur, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int idx;
    logic [3*M-1:0] stream[8];
    logic [TE-1:0]  stream_te[8];
    logic [3:0]     pat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mant_in = '0; te_in = '0; sign_in = 1'b0; special_in = 2'b00;
    do_reset();

    // Directed rounding/saturation/special cases.
    step(1'b1, {1'b0, 14'h2000, 27'h0}, 7'd3, 1'b0, 2'b00, 1'b1, a);
    step(1'b0, '0, '0, 1'b0, 2'b00, 1'b1, a);
    step(1'b0, '0, '0, 1'b0, 2'b00, 1'b1, a);
    step(1'b1, {1'b0, 14'h3FFF, 1'b1, 26'h1}, 7'd5, 1'b1, 2'b00, 1'b1, a);
    step(1'b1, {1'b0, 14'h2000, 1'b1, 26'h0}, 7'd2, 1'b0, 2'b00, 1'b1, a);
    step(1'b1, {1'b0, 14'h2001, 1'b1, 26'h0}, 7'd2, 1'b0, 2'b00, 1'b1, a);
    step(1'b1, {1'b0, 14'h3FFF, 1'b1, 26'h1}, 7'd63, 1'b0, 2'b00, 1'b1, a);
    step(1'b1, {1'b0, 14'h3FFF, 1'b0, 26'h3FFFFFF}, 7'd63, 1'b0, 2'b00, 1'b1, a);
    step(1'b1, {1'b0, 14'h3FFF, 1'b1, 26'h1}, 7'h70, 1'b1, 2'b00, 1'b1, a);
    step(1'b1, {1'b0, 14'h3FFF, 1'b1, 26'h1}, 7'd9, 1'b1, 2'b01, 1'b1, a);
    step(1'b1, {1'b0, 14'h2ABC, 1'b1, 26'h0}, 7'd63, 1'b0, 2'b10, 1'b1, a);
    drain();

    // Eight back-to-back inputs against a 1,0,0,1 ready pattern.
    pat = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      stream[i] = rnd_mant();
      stream_te[i] = TE'($urandom_range(0, 127));
    end
    idx = 0;
    for (int c = 0; c < 100 && idx < 8; c++) begin
      step(1'b1, stream[idx], stream_te[idx], idx[0], 2'b00, pat[3 - (c % 4)], a);
      if (a) idx++;
    end
    chk("stream_accepted", idx, 8);
    drain();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      logic [3*M-1:0] m;
      logic [TE-1:0]  t;
      logic [1:0]     sp;
      m  = rnd_mant();
      t  = TE'($urandom_range(0, 127));
      sp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
      if ($urandom_range(0, 7) == 0) begin
        m = {1'b0, 14'h3FFF, 1'b1, 26'($urandom())};
        t = 7'd63;
      end else if ($urandom_range(0, 7) == 0) begin
        m[2*M-3:0] = '0;
      end
      step($urandom_range(0, 3) != 0, m, t, 1'($urandom()), sp, $urandom_range(0, 2) != 0, a);
    end
    drain();

    // Reset with two results in flight.
    step(1'b1, rnd_mant(), 7'd4, 1'b0, 2'b00, 1'b0, a);
    step(1'b1, rnd_mant(), 7'd8, 1'b1, 2'b00, 1'b0, a);
    step(1'b0, '0, '0, 1'b0, 2'b00, 1'b0, a);
    chk("inflight_before_rst", q.size(), 2);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 2'b00, 1'b1, a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
